// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared sizes, index type and state encoding for the round-robin mux arbiter
package mux_rr_arbiter_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: circular first-set search over req starting at index start (ports: req, start -> idx, found)
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             start,
  output idx_t             idx,
  output logic             found
);
  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[idx_t'(start + idx_t'(i))]) begin
        idx = idx_t'(start + idx_t'(i));
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 8-way round-robin arbiter with hold limit driving an 8:1 data mux (ports: clk, rst, req, data_in -> gnt, sel, valid, data_out)
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  output logic [N_REQ-1:0] gnt,
  output idx_t             sel,
  output logic             valid,
  output logic             data_out
);
  state_t     state;
  idx_t       ptr;
  logic [3:0] hold_cnt;
  idx_t       start;
  idx_t       pick_idx;
  logic       pick_found;
  logic       release_now;
  // While granting, search from the owner's successor so the owner itself is considered last.
  assign start = idx_t'((state == GRANT ? sel : ptr) + idx_t'(1));
  assign release_now = !req[sel] || hold_cnt == 4'(MAX_HOLD - 1);
  assign data_out = valid & data_in[sel];
  rr_pick u_pick (
    .req   (req),
    .start (start),
    .idx   (pick_idx),
    .found (pick_found)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      sel <= '0;
      valid <= 1'b0;
      hold_cnt <= '0;
      ptr <= idx_t'(N_REQ - 1);
    end else if (state == GRANT && !release_now) begin
      hold_cnt <= hold_cnt + 4'd1;
    end else if (pick_found) begin
      state <= GRANT;
      gnt <= (N_REQ)'(1) << pick_idx;
      sel <= pick_idx;
      valid <= 1'b1;
      hold_cnt <= '0;
      ptr <= pick_idx;
    end else begin
      state <= IDLE;
      gnt <= '0;
      sel <= '0;
      valid <= 1'b0;
      hold_cnt <= '0;
    end
  end
endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive grant cycles per owner (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 8, one request line per requester, index 0..7.
REQ-005 The block SHALL have port data_in, input, 8, the 1-bit data of each requester, index 0..7.
REQ-006 The block SHALL have port gnt, output, 8, the one-hot grant, registered.
REQ-007 The block SHALL have port sel, output, 3, the binary index of the current owner, registered, driving the 8:1 select.
REQ-008 The block SHALL have port valid, output, 1, which is high while any grant is active, registered.
REQ-009 The block SHALL have port data_out, output, 1, equal to data_in[sel] when valid=1 and 0 otherwise (combinational from sel).

Function
REQ-010 The block SHALL have the states IDLE (no owner) and GRANT (owner = sel).
REQ-011 IDLE: if req!=0 at an edge, the block SHALL enter GRANT at that edge, owner = first set req index searching circularly from ptr+1; otherwise it SHALL stay in IDLE.
REQ-012 Grant latency SHALL be exactly 1 cycle: a req sampled at edge t gives gnt/sel/valid visible after edge t.
REQ-013 ptr (last owner) SHALL update to the owner index on every new grant; the reset value SHALL be 7, so requester 0 has first priority.
REQ-014 hold_cnt (4-bit) SHALL be 0 on each new grant and SHALL increment every cycle the same grant is held.
REQ-015 GRANT release SHALL occur at an edge where req[sel]==0 or hold_cnt==MAX_HOLD-1.
REQ-016 On release with req!=0, the block SHALL grant the next owner at the same edge with no idle bubble, searching circularly from sel+1; the current owner SHALL be included last.
REQ-017 On release with req==0, the block SHALL go to IDLE: gnt=0, valid=0, sel=0.
REQ-018 Owner still requesting at hold expiry with no other request SHALL be re-granted with hold_cnt=0 (gnt stays continuous).
REQ-019 The circular search SHALL wrap 7 -> 0.
REQ-020 The block SHALL enforce these invariants: gnt SHALL be one-hot or zero; gnt[sel]==valid; gnt==0 whenever valid==0.
REQ-021 Requests from non-owners SHALL never pre-empt the current owner before release.

Reset
REQ-022 While rst=1 at an edge, the block SHALL set state=IDLE, gnt=0, sel=0, valid=0, hold_cnt=0, ptr=7; rst SHALL override all other inputs.
REQ-023 Reset mid-grant SHALL drop the grant at the next edge; arbitration SHALL resume on the first edge after rst deasserts, with fresh priority (ptr=7).

Structure
REQ-024 State encoding (IDLE/GRANT), requester count 8 and index width 3 SHALL live in a shared package.
REQ-025 The circular first-set search SHALL be one sub-module, rr_pick (inputs req[7:0] and start[2:0]; outputs idx[2:0] and found), used for both IDLE grant and release handoff.

Verification
REQ-026 Scenario: rst=1 for 2 cycles with req=8'hFF -> gnt=0, sel=0, valid=0, data_out=0; first edge after rst=0 -> gnt=8'h01, sel=0.
REQ-027 Scenario: MAX_HOLD=4, req=8'hFF constant -> owners 0,1,...,7,0 in turn, each for exactly 4 cycles, with no bubble between them.
REQ-028 Scenario: req=8'h08 for 10 cycles, data_in=8'h08 -> gnt=8'h08 continuous, sel=3, data_out=1 throughout, hold_cnt 0,1,2,3,0,...
REQ-029 Scenario: owner 7 with req=8'h81 drops req[7] -> next cycle gnt=8'h01 (wrap-around).
REQ-030 Scenario: owner 2 drops req with req otherwise 0 -> next cycle valid=0, gnt=0, sel=0; req[2] reasserted -> grant to 2 after 1 cycle.
REQ-031 Scenario: rst pulsed while owner 6 holds, req=8'h24 -> grant dropped; after release gnt=8'h04 (ptr reset, index 2 first).
